hdmi_tmds_serializer: RTL and testbench

//  Bit-clock-domain stage fed by the HDMI PLL (125 MHz from a 25 MHz pixel clock, 5x).

---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/tmds_ddr_shifter.sv | 32 +++
 rtl/hdmi_tmds_serializer.sv | 133 +++++++++++++
 tb/tb_hdmi_tmds_serializer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI TMDS bit-clock serializer.
// Channel indices match the bit positions on the DDR output buses.
package hdmi_pkg;

    localparam int TMDS_WORD_W = 10;
    localparam int NUM_CH      = 4;

    localparam logic [TMDS_WORD_W-1:0] TMDS_CLK_WORD = 10'b0000011111;

    localparam int CH_BLUE  = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_RED   = 2;
    localparam int CH_CLK   = 3;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

endpackage

// File: rtl/tmds_ddr_shifter.sv
// One TMDS lane: emits a 10-bit word LSB first as five DDR bit pairs.
// pair[0] goes out on the rising edge, pair[1] on the falling edge.
module tmds_ddr_shifter
    import hdmi_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [TMDS_WORD_W-1:0] i_load_word,
    input  logic                   i_clear,
    output logic [1:0]             o_pair
);

    logic [7:0] r_sr;
    logic [1:0] r_pair;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sr   <= '0;
            r_pair <= '0;
        end else if (i_load) begin
            r_pair <= i_load_word[1:0];
            r_sr   <= i_load_word[9:2];
        end else begin
            r_pair <= r_sr[1:0];
            r_sr   <= {2'b00, r_sr[7:2]};
        end
    end

    assign o_pair = r_pair;

endmodule

// File: rtl/hdmi_tmds_serializer.sv
// Bit-clock stage: lock gating, 5-phase pixel sequencing and word capture
// feeding four DDR shifters (blue, green, red, TMDS clock).
module hdmi_tmds_serializer
    import hdmi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_pll_locked,
    input  logic [TMDS_WORD_W-1:0] i_tmds_red,
    input  logic [TMDS_WORD_W-1:0] i_tmds_green,
    input  logic [TMDS_WORD_W-1:0] i_tmds_blue,
    output logic                   o_pixel_strobe,
    output logic                   o_active,
    output logic [NUM_CH-1:0]      o_tmds_d0,
    output logic [NUM_CH-1:0]      o_tmds_d1
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [2:0]             r_phase;
    logic [2:0]             w_phase_nxt;
    logic [TMDS_WORD_W-1:0] r_cap_r;
    logic [TMDS_WORD_W-1:0] r_cap_g;
    logic [TMDS_WORD_W-1:0] r_cap_b;
    logic                   r_strobe;
    logic                   r_active;
    logic                   w_run;
    logic                   w_load;
    logic                   w_capture;
    logic                   w_clear;
    logic [TMDS_WORD_W-1:0] w_word [NUM_CH];
    logic [1:0]             w_pair [NUM_CH];

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_phase_nxt = 3'd0;
        if (!r_sync2) begin
            w_state_nxt = WAIT_LOCK;
            w_count_nxt = '0;
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    w_state_nxt = SETTLE;
                    w_count_nxt = '0;
                end
                SETTLE: begin
                    if (r_count == CNT_LAST) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
                RUN: begin
                    w_phase_nxt = (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign w_run     = (r_state == RUN);
    assign w_load    = w_run && (r_phase == 3'd0);
    assign w_capture = w_run && (r_phase == 3'd4);
    // Leaving RUN flushes the lanes, so a word cut mid-way never reaches the pins.
    assign w_clear   = (w_state_nxt != RUN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= WAIT_LOCK;
            r_count  <= '0;
            r_phase  <= 3'd0;
            r_cap_r  <= '0;
            r_cap_g  <= '0;
            r_cap_b  <= '0;
            r_strobe <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_sync1  <= i_pll_locked;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_phase  <= w_phase_nxt;
            r_strobe <= (w_state_nxt == RUN) && (w_phase_nxt == 3'd4);
            r_active <= (w_state_nxt == RUN);
            if (w_clear) begin
                r_cap_r <= '0;
                r_cap_g <= '0;
                r_cap_b <= '0;
            end else if (w_capture) begin
                r_cap_r <= i_tmds_red;
                r_cap_g <= i_tmds_green;
                r_cap_b <= i_tmds_blue;
            end
        end
    end

    assign w_word[CH_BLUE]  = r_cap_b;
    assign w_word[CH_GREEN] = r_cap_g;
    assign w_word[CH_RED]   = r_cap_r;
    assign w_word[CH_CLK]   = TMDS_CLK_WORD;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        tmds_ddr_shifter u_shift (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_load      (w_load),
            .i_load_word (w_word[ch]),
            .i_clear     (w_clear),
            .o_pair      (w_pair[ch])
        );
        assign o_tmds_d0[ch] = w_pair[ch][0];
        assign o_tmds_d1[ch] = w_pair[ch][1];
    end

    assign o_pixel_strobe = r_strobe;
    assign o_active       = r_active;

endmodule

// File: tb/tb_hdmi_tmds_serializer.sv
// Directed bench for hdmi_tmds_serializer with a short settle window.
// Outputs are sampled 1 time unit after each rising edge.
module tb_hdmi_tmds_serializer;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll;
    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
    logic       strobe;
    logic       active;
    logic [3:0] d0;
    logic [3:0] d1;

    int total = 0;
    int bad   = 0;

    always #4 clk = ~clk;

    hdmi_tmds_serializer #(
        .SETTLE_CYCLES (N)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_pll_locked   (pll),
        .i_tmds_red     (red),
        .i_tmds_green   (green),
        .i_tmds_blue    (blue),
        .o_pixel_strobe (strobe),
        .o_active       (active),
        .o_tmds_d0      (d0),
        .o_tmds_d1      (d1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(output bit found);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (strobe === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [9:0] exp;
        reset = 1'b1;
        pll   = 1'b1;
        red   = '0;
        green = '0;
        blue  = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({strobe, active, d0, d1} !== 10'b0) begin
                bad++;
                $display("FAIL reset_hold: got %b want %b", {strobe, active, d0, d1}, 10'b0);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            exp = {(i == N + 3), 9'b0};
            total++;
            if ({active, strobe, d0, d1} !== exp) begin
                bad++;
                $display("FAIL reset_settle[%0d]: got %b want %b", i, {active, strobe, d0, d1}, exp);
            end
        end
    endtask

    task automatic test_words;
        bit         found;
        logic [9:0] gr;
        logic [9:0] gg;
        logic [9:0] gb;
        logic [9:0] gc;
        wait_strobe(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL words_strobe: got none want strobe");
        end
        red   = 10'h2B5;
        green = 10'h0FF;
        blue  = 10'h155;
        tick();
        total++;
        if ({d1[2:0], d0[2:0]} !== 6'b0) begin
            bad++;
            $display("FAIL words_early: got %b want 000000", {d1[2:0], d0[2:0]});
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            gb[2*k] = d0[0]; gb[2*k+1] = d1[0];
            gg[2*k] = d0[1]; gg[2*k+1] = d1[1];
            gr[2*k] = d0[2]; gr[2*k+1] = d1[2];
            gc[2*k] = d0[3]; gc[2*k+1] = d1[3];
        end
        total++;
        if (gr !== 10'h2B5) begin
            bad++;
            $display("FAIL words_red: got %h want 2b5", gr);
        end
        total++;
        if (gg !== 10'h0FF) begin
            bad++;
            $display("FAIL words_green: got %h want 0ff", gg);
        end
        total++;
        if (gb !== 10'h155) begin
            bad++;
            $display("FAIL words_blue: got %h want 155", gb);
        end
        total++;
        if (gc !== 10'h01F) begin
            bad++;
            $display("FAIL words_clk: got %h want 01f", gc);
        end
    endtask

    task automatic test_stream;
        bit         found;
        logic [9:0] wr [21];
        logic [9:0] wg [21];
        logic [9:0] wb [21];
        logic [9:0] gr;
        logic [9:0] gg;
        logic [9:0] gb;
        logic [9:0] gc;
        for (int p = 0; p < 21; p++) begin
            wr[p] = 10'(p * 97 + 13);
            wg[p] = 10'(p * 211 + 700);
            wb[p] = 10'(1023 - p * 45);
        end
        wait_strobe(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stream_strobe: got none want strobe");
        end
        red   = wr[0];
        green = wg[0];
        blue  = wb[0];
        tick();
        for (int p = 0; p < 20; p++) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                gb[2*k] = d0[0]; gb[2*k+1] = d1[0];
                gg[2*k] = d0[1]; gg[2*k+1] = d1[1];
                gr[2*k] = d0[2]; gr[2*k+1] = d1[2];
                gc[2*k] = d0[3]; gc[2*k+1] = d1[3];
                total++;
                if (strobe !== (k == 3)) begin
                    bad++;
                    $display("FAIL stream_period[%0d.%0d]: got %b want %b", p, k, strobe, (k == 3));
                end
                if (k == 3) begin
                    red   = wr[p+1];
                    green = wg[p+1];
                    blue  = wb[p+1];
                end
            end
            total++;
            if ({gr, gg, gb} !== {wr[p], wg[p], wb[p]}) begin
                bad++;
                $display("FAIL stream_data[%0d]: got %h %h %h want %h %h %h",
                         p, gr, gg, gb, wr[p], wg[p], wb[p]);
            end
            total++;
            if (gc !== 10'h01F) begin
                bad++;
                $display("FAIL stream_clk[%0d]: got %h want 01f", p, gc);
            end
        end
    endtask

    task automatic test_lock_drop;
        bit         found;
        logic [9:0] ck;
        logic [1:0] exp_c;
        ck = 10'b0000011111;
        wait_strobe(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL drop_strobe: got none want strobe");
        end
        tick();
        tick();
        tick();
        pll = 1'b0;
        tick();
        tick();
        total++;
        if ({active, strobe} !== 2'b11) begin
            bad++;
            $display("FAIL drop_early: got %b want 11", {active, strobe});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({strobe, active, d0, d1} !== 10'b0) begin
                bad++;
                $display("FAIL drop_off[%0d]: got %b want %b", i, {strobe, active, d0, d1}, 10'b0);
            end
        end
        red   = 10'h3FF;
        green = 10'h3FF;
        blue  = 10'h3FF;
        pll   = 1'b1;
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            total++;
            if ({active, d0, d1} !== {(i == N + 3), 8'b0}) begin
                bad++;
                $display("FAIL drop_resettle[%0d]: got %b want %b", i, {active, d0, d1}, {(i == N + 3), 8'b0});
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_c = {ck[2*k+1], ck[2*k]};
            total++;
            if ({d1[3], d0[3], d1[2:0], d0[2:0]} !== {exp_c, 6'b0}) begin
                bad++;
                $display("FAIL drop_first_word[%0d]: got %b want %b", k,
                         {d1[3], d0[3], d1[2:0], d0[2:0]}, {exp_c, 6'b0});
            end
        end
        tick();
        total++;
        if ({d1, d0} !== 8'hFF) begin
            bad++;
            $display("FAIL drop_second_word: got %h want ff", {d1, d0});
        end
    endtask

    task automatic test_glitch;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL glitch_pre: got %b want 0", active);
        end
        pll = 1'b0;
        tick();
        pll = 1'b1;
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            total++;
            if (active !== (i == N + 3)) begin
                bad++;
                $display("FAIL glitch_settle[%0d]: got %b want %b", i, active, (i == N + 3));
            end
        end
    endtask

    task automatic test_reset_run;
        bit found;
        wait_strobe(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rrun_strobe: got none want strobe");
        end
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({strobe, active, d0, d1} !== 10'b0) begin
                bad++;
                $display("FAIL rrun_off[%0d]: got %b want %b", i, {strobe, active, d0, d1}, 10'b0);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= N + 3; i++) begin
            tick();
            total++;
            if (active !== (i == N + 3)) begin
                bad++;
                $display("FAIL rrun_settle[%0d]: got %b want %b", i, active, (i == N + 3));
            end
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (strobe !== (i == 4)) begin
                bad++;
                $display("FAIL rrun_restart[%0d]: got %b want %b", i, strobe, (i == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_words();
        test_stream();
        test_lock_drop();
        test_glitch();
        test_reset_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
